muldiv_ctrl: RTL and testbench

Sequencing controller for the EX-stage multiply/divide resources of the MIPS core. It accepts a MULT/MULTU/DIV/DIVU operation from EX and drives the pipelined multiplier or the iterative divider. It holds the pipeline with a stall request until the 64-bit {HI,LO} result is captured, and cancels in-flight work on an exception flush. It sits between the EX-stage ALU and the hazard unit; the ALU selects its `result` for mul/div ops.

---
 rtl/muldiv_ctrl.sv | 117 +++++++++++
 tb/tb_muldiv_ctrl.sv | 203 ++++++++++++++++++++
 2 files changed

// File: rtl/muldiv_ctrl.sv
// EX-stage multiply/divide sequencer: drives the pipelined multiplier or the
// iterative divider, stalls the front end until {HI,LO} is captured.
module muldiv_ctrl #(
  parameter int MUL_LATENCY = 2
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        op_valid,
  input  logic [1:0]  op_code,
  input  logic [31:0] src_a,
  input  logic [31:0] src_b,
  input  logic        pipe_stall,
  input  logic        flush,
  output logic [31:0] mul_a,
  output logic [31:0] mul_b,
  output logic        mul_signed,
  input  logic [63:0] mul_result,
  output logic        div_start,
  output logic        div_signed,
  output logic [31:0] div_a,
  output logic [31:0] div_b,
  output logic        div_annul,
  input  logic        div_ready,
  input  logic [63:0] div_result,
  output logic        stall_req,
  output logic [63:0] result,
  output logic        result_valid
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    MUL  = 2'd1,
    DIV  = 2'd2,
    DONE = 2'd3
  } state_t;

  state_t      state;
  logic [3:0]  cnt;
  logic [31:0] opa;
  logic [31:0] opb;
  logic        sgn;
  logic        is_div;
  logic        zero_div;

  // op_code[1] selects divide, op_code[0] selects the unsigned variant
  assign is_div   = op_code[1];
  assign zero_div = is_div && (src_b == 32'd0);

  // NOTE: every register here is written with <= so all updates take effect
  // together at the edge, independent of statement order.
  always_ff @(posedge clk) begin
    if (rst) begin
      state  <= IDLE;
      cnt    <= 4'd0;
      opa    <= 32'd0;
      opb    <= 32'd0;
      sgn    <= 1'b0;
      result <= 64'd0;
    end else if (flush) begin
      state <= IDLE;
    end else begin
      case (state)
        IDLE: begin
          if (op_valid) begin
            opa <= src_a;
            opb <= src_b;
            sgn <= ~op_code[0];
            if (!is_div) begin
              state <= MUL;
              cnt   <= 4'(MUL_LATENCY - 1);
            end else if (zero_div) begin
              state  <= DONE;
              result <= 64'd0;
            end else begin
              state <= DIV;
            end
          end
        end
        MUL: begin
          if (cnt == 4'd0) begin
            result <= mul_result;
            state  <= DONE;
          end else begin
            cnt <= cnt - 4'd1;
          end
        end
        DIV: begin
          if (div_ready) begin
            result <= div_result;
            state  <= DONE;
          end
        end
        DONE: begin
          // Hold while the op is still parked in EX.
          if (!pipe_stall) state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign mul_a      = opa;
  assign mul_b      = opb;
  assign mul_signed = sgn;
  assign div_a      = opa;
  assign div_b      = opb;
  assign div_signed = sgn;

  assign stall_req    = !flush &&
                        ((state == IDLE && op_valid && !zero_div) ||
                         state == MUL || state == DIV);
  assign div_start    = !rst && !flush && (state == DIV) && !div_ready;
  // A flush while the divider is busy must abort it; reset clears it anyway.
  assign div_annul    = !rst && flush && (state == DIV);
  assign result_valid = (state == DONE);

endmodule

// File: tb/tb_muldiv_ctrl.sv
// Directed bench for muldiv_ctrl: table of mul/div ops with hand-computed
// results and timing, plus flush, stall-in-DONE and reset sequences.
module tb_muldiv_ctrl;

  logic        clk = 1'b0;
  logic        rst;
  logic        op_valid;
  logic [1:0]  op_code;
  logic [31:0] src_a, src_b;
  logic        pipe_stall, flush;
  logic [31:0] mul_a, mul_b;
  logic        mul_signed;
  logic [63:0] mul_result;
  logic        div_start, div_signed, div_annul, div_ready;
  logic [31:0] div_a, div_b;
  logic [63:0] div_result;
  logic        stall_req;
  logic [63:0] result;
  logic        result_valid;

  int n_checks = 0;
  int n_fail   = 0;
  int dcnt;

  always #5 clk = ~clk;

  muldiv_ctrl #(.MUL_LATENCY(2)) dut (
    .clk(clk), .rst(rst), .op_valid(op_valid), .op_code(op_code),
    .src_a(src_a), .src_b(src_b), .pipe_stall(pipe_stall), .flush(flush),
    .mul_a(mul_a), .mul_b(mul_b), .mul_signed(mul_signed),
    .mul_result(mul_result), .div_start(div_start), .div_signed(div_signed),
    .div_a(div_a), .div_b(div_b), .div_annul(div_annul),
    .div_ready(div_ready), .div_result(div_result), .stall_req(stall_req),
    .result(result), .result_valid(result_valid)
  );

  // Two-cycle multiplier: one register stage after the operand registers.
  always @(posedge clk)
    mul_result <= mul_signed ? ({{32{mul_a[31]}}, mul_a} * {{32{mul_b[31]}}, mul_b})
                             : ({32'd0, mul_a} * {32'd0, mul_b});

  // Divider answers after 33 cycles of div_start.
  always @(posedge clk) dcnt <= div_start ? dcnt + 1 : 0;
  assign div_ready = (dcnt == 33);

  always_comb begin
    div_result = 64'd0;
    if (div_b != 32'd0) begin
      if (div_signed)
        div_result = {32'($signed(div_a) % $signed(div_b)),
                      32'($signed(div_a) / $signed(div_b))};
      else
        div_result = {div_a % div_b, div_a / div_b};
    end
  end

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic next_cycle();
    @(posedge clk);
    #1;
  endtask

  typedef struct {
    string       name;
    logic [1:0]  code;
    logic [31:0] a;
    logic [31:0] b;
    logic [63:0] exp_res;
    int          exp_done;    // cycle in which result_valid first rises
    int          exp_stall;   // stall_req high for cycles 0..exp_stall-1
    int          exp_dstart;  // number of cycles with div_start high
  } vec_t;

  // Runs one op starting now (just after a posedge), pipe_stall low.
  task automatic run_op(input vec_t v);
    int stall_err = 0, done_at = -1, dstart_n = 0;
    logic [63:0] res_done = '0, ops_c1 = '0;
    op_valid = 1'b1; op_code = v.code; src_a = v.a; src_b = v.b;
    for (int c = 0; c < 100 && done_at < 0; c++) begin
      @(negedge clk);
      if (stall_req !== (c < v.exp_stall)) stall_err++;
      if (div_start === 1'b1) dstart_n++;
      if (c == 1) ops_c1 = {mul_a, mul_b};
      if (result_valid === 1'b1) begin
        done_at  = c;
        res_done = result;
      end
      next_cycle();
    end
    op_valid = 1'b0;
    check({v.name, "_result"}, res_done, v.exp_res);
    check({v.name, "_done_cycle"}, 64'(done_at), 64'(v.exp_done));
    check({v.name, "_stall_errs"}, 64'(stall_err), 64'd0);
    check({v.name, "_div_start_cycles"}, 64'(dstart_n), 64'(v.exp_dstart));
    check({v.name, "_operands"}, ops_c1, {v.a, v.b});
    @(negedge clk);
    check({v.name, "_valid_after"}, 64'(result_valid), 64'd0);
    next_cycle();
  endtask

  vec_t vecs[8];

  initial begin
    logic [63:0] prev;
    int done_n, stable_err;

    vecs[0] = '{"mult_neg",  2'b00, 32'hFFFFFFFE, 32'd3,        64'hFFFFFFFF_FFFFFFFA, 3, 3, 0};
    vecs[1] = '{"multu",     2'b01, 32'hFFFFFFFE, 32'd3,        64'h00000002_FFFFFFFA, 3, 3, 0};
    vecs[2] = '{"div_neg",   2'b10, 32'hFFFFFFF9, 32'd2,        64'hFFFFFFFF_FFFFFFFD, 35, 35, 33};
    vecs[3] = '{"divu_zero", 2'b11, 32'd5,        32'd0,        64'h0,                 1, 0, 0};
    vecs[4] = '{"divu",      2'b11, 32'd100,      32'd7,        64'h00000002_0000000E, 35, 35, 33};
    vecs[5] = '{"mult_max",  2'b00, 32'h7FFFFFFF, 32'h7FFFFFFF, 64'h3FFFFFFF_00000001, 3, 3, 0};
    vecs[6] = '{"div_negb",  2'b10, 32'd7,        32'hFFFFFFFE, 64'h00000001_FFFFFFFD, 35, 35, 33};
    vecs[7] = '{"multu_max", 2'b01, 32'hFFFFFFFF, 32'hFFFFFFFF, 64'hFFFFFFFE_00000001, 3, 3, 0};

    rst = 1'b1; op_valid = 1'b0; op_code = 2'b00; src_a = '0; src_b = '0;
    pipe_stall = 1'b0; flush = 1'b0;
    repeat (2) next_cycle();
    @(negedge clk);
    check("rst_result", result, 64'd0);
    check("rst_flags", {60'd0, result_valid, stall_req, div_start, div_annul}, 64'd0);
    check("rst_operands", {mul_a, mul_b}, 64'd0);
    check("rst_sgn", {62'd0, mul_signed, div_signed}, 64'd0);
    next_cycle();
    rst = 1'b0;
    next_cycle();

    foreach (vecs[i]) run_op(vecs[i]);

    // Flush in the middle of a divide.
    prev = result;
    op_valid = 1'b1; op_code = 2'b10; src_a = 32'd50; src_b = 32'd5;
    repeat (10) next_cycle();
    flush = 1'b1;
    @(negedge clk);
    check("flush_annul", 64'(div_annul), 64'd1);
    check("flush_start_low", {62'd0, div_start, stall_req}, 64'd0);
    next_cycle();
    flush = 1'b0; op_valid = 1'b0;
    @(negedge clk);
    check("flush_after", {61'd0, div_annul, result_valid, stall_req}, 64'd0);
    check("flush_result_held", result, prev);
    next_cycle();
    @(negedge clk);
    check("flush_idle_no_start", 64'(div_start), 64'd0);
    next_cycle();

    // Flush in the same cycle div_ready rises: no capture.
    op_valid = 1'b1; op_code = 2'b10; src_a = 32'd50; src_b = 32'd5;
    repeat (34) next_cycle();
    flush = 1'b1;
    @(negedge clk);
    check("flush_ready_annul", {62'd0, div_annul, div_start}, 64'd2);
    next_cycle();
    flush = 1'b0; op_valid = 1'b0;
    @(negedge clk);
    check("flush_ready_no_capture", result, prev);
    check("flush_ready_valid", 64'(result_valid), 64'd0);
    next_cycle();

    // MULT held in DONE by pipe_stall for 3 cycles, then a back-to-back MULT.
    op_valid = 1'b1; op_code = 2'b00; src_a = 32'd6; src_b = 32'hFFFFFFF9;
    done_n = 0; stable_err = 0;
    for (int c = 0; c < 7; c++) begin
      pipe_stall = (c >= 3 && c <= 5);
      @(negedge clk);
      if (result_valid === 1'b1) begin
        done_n++;
        if (result !== 64'hFFFFFFFF_FFFFFFD6) stable_err++;
      end
      next_cycle();
    end
    pipe_stall = 1'b0;
    check("hold_done_cycles", 64'(done_n), 64'd4);
    check("hold_result_stable_errs", 64'(stable_err), 64'd0);
    run_op('{"mult_b2b", 2'b00, 32'd1000, 32'd1000, 64'd1000000, 3, 3, 0});

    // Synchronous reset in the middle of a divide.
    op_valid = 1'b1; op_code = 2'b11; src_a = 32'd9; src_b = 32'd4;
    repeat (5) next_cycle();
    rst = 1'b1;
    @(negedge clk);
    check("rst_mid_annul", 64'(div_annul), 64'd0);
    next_cycle();
    rst = 1'b0; op_valid = 1'b0;
    @(negedge clk);
    check("rst_mid_result", result, 64'd0);
    check("rst_mid_flags", {61'd0, result_valid, stall_req, div_start}, 64'd0);
    check("rst_mid_operands", {mul_a, mul_b}, 64'd0);
    next_cycle();

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
